// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default reset PC, the bubble instruction word and a PC increment helper.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN     = 2'd0,
    FETCH_HOLD    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // sll $0,$0,0 -- architectural nop, used as the bubble instruction
  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;

  // 32-bit modulo increment; 32'hFFFF_FFFC wraps to 0
  function automatic logic [31:0] pc_plus_four(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/ready port.
//   imem_req   : fetch -> memory, request valid
//   imem_addr  : fetch -> memory, word address, stable while waiting
//   imem_ready : memory -> fetch, response valid this cycle
//   imem_rdata : memory -> fetch, instruction word when imem_ready=1
// master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface : fetch_stage_if

// File: rtl/fetch_stage_fetch_decode_register.sv
// -----------------------------------------------------------------------------
// fetch_decode_register
// Pipeline register between fetch and decode.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   load_i            : capture {instr_i, pc_plus_four_i} as a valid entry
//   bubble_i          : replace contents with a nop bubble (wins over load_i)
//   instr_i           : instruction word to capture
//   pc_plus_four_i    : pc+4 of that instruction
//   instruction_o     : registered instruction to decode
//   pc_plus_four_o    : registered pc+4 to decode
//   valid_o           : 1 = real instruction, 0 = bubble
// With neither load_i nor bubble_i the register holds (stall).
// -----------------------------------------------------------------------------
module fetch_decode_register
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus_four_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_plus_four_o,
  output logic        valid_o
);

  logic [31:0] instruction_q, instruction_d;
  logic [31:0] pc_plus_four_q, pc_plus_four_d;
  logic        valid_q, valid_d;

  always_comb begin
    instruction_d  = instruction_q;
    pc_plus_four_d = pc_plus_four_q;
    valid_d        = valid_q;
    if (bubble_i) begin
      instruction_d  = NOP_INSTRUCTION;
      pc_plus_four_d = 32'h0;
      valid_d        = 1'b0;
    end else if (load_i) begin
      instruction_d  = instr_i;
      pc_plus_four_d = pc_plus_four_i;
      valid_d        = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instruction_q  <= NOP_INSTRUCTION;
      pc_plus_four_q <= 32'h0;
      valid_q        <= 1'b0;
    end else begin
      instruction_q  <= instruction_d;
      pc_plus_four_q <= pc_plus_four_d;
      valid_q        <= valid_d;
    end
  end

  assign instruction_o  = instruction_q;
  assign pc_plus_four_o = pc_plus_four_q;
  assign valid_o        = valid_q;

endmodule : fetch_decode_register

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: PC register, request/ready instruction-memory port and
// the fetch/decode pipeline register. Taken branches/jumps from decode squash
// the wrong-path fetch (no delay slot).
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   stall_D         : hazard stall, freezes PC and fetch/decode register
//   pc_src_D        : redirect request from decode
//   jump_address_D  : redirect target
//   imem            : instruction-memory port (master side)
//   instruction_D   : instruction to decode
//   pc_plus_four_D  : pc+4 to decode
//   valid_D         : 1 = instruction_D is real, 0 = bubble
//   pc_F            : current PC (trace)
//
// state         | meaning
// --------------+-------------------------------------------------------------
// FETCH_RUN     | request outstanding at pc; normal fetching
// FETCH_HOLD    | response arrived during a stall, word parked in hold_buf
// FETCH_DISCARD | redirected while a request was pending; wait out and drop it
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall_D,
  input  logic                pc_src_D,
  input  logic [31:0]         jump_address_D,
  fetch_stage_if.master       imem,
  output logic [31:0]         instruction_D,
  output logic [31:0]         pc_plus_four_D,
  output logic                valid_D,
  output logic [31:0]         pc_F
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_buf_q, hold_buf_d;
  logic [31:0]  discard_addr_q, discard_addr_d;

  logic         fd_load;
  logic         fd_bubble;
  logic [31:0]  fd_instr;
  logic [31:0]  pc_inc;
  logic         redirect;
  logic         req_int;
  logic [31:0]  addr_int;

  // A redirect only counts when decode holds a real instruction and is not
  // stalled; otherwise pc_src_D may be stale.
  assign redirect = pc_src_D & valid_D & ~stall_D;
  assign pc_inc   = pc_plus_four(pc_q);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_buf_d     = hold_buf_q;
    discard_addr_d = discard_addr_q;
    fd_load        = 1'b0;
    fd_bubble      = 1'b0;
    fd_instr       = imem.imem_rdata;
    req_int        = 1'b1;
    addr_int       = pc_q;

    unique case (state_q)
      FETCH_RUN: begin
        if (imem.imem_ready) begin
          if (redirect) begin
            fd_bubble = 1'b1;
            pc_d      = jump_address_D;
          end else if (stall_D) begin
            hold_buf_d = imem.imem_rdata;
            state_d    = FETCH_HOLD;
          end else begin
            fd_load = 1'b1;
            pc_d    = pc_inc;
          end
        end else begin
          if (redirect) begin
            // Request to pc is still in flight; remember its address so the
            // port stays stable until the stale response is consumed.
            discard_addr_d = pc_q;
            pc_d           = jump_address_D;
            fd_bubble      = 1'b1;
            state_d        = FETCH_DISCARD;
          end else if (!stall_D) begin
            fd_bubble = 1'b1;
          end
        end
      end

      FETCH_HOLD: begin
        req_int = 1'b0;
        if (!stall_D) begin
          state_d = FETCH_RUN;
          if (redirect) begin
            fd_bubble = 1'b1;
            pc_d      = jump_address_D;
          end else begin
            fd_load  = 1'b1;
            fd_instr = hold_buf_q;
            pc_d     = pc_inc;
          end
        end
      end

      FETCH_DISCARD: begin
        addr_int  = discard_addr_q;
        fd_bubble = ~stall_D;
        if (imem.imem_ready) begin
          state_d = FETCH_RUN;
        end
      end

      default: begin
        state_d = FETCH_RUN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= FETCH_RUN;
      pc_q           <= RESET_PC;
      hold_buf_q     <= 32'h0;
      discard_addr_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_buf_q     <= hold_buf_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  // Gate with reset so no request is visible while reset is asserted.
  assign imem.imem_req  = req_int & ~reset;
  assign imem.imem_addr = addr_int;
  assign pc_F           = pc_q;

  fetch_decode_register u_fd_reg (
    .clk_i          (clock),
    .rst_i          (reset),
    .load_i         (fd_load),
    .bubble_i       (fd_bubble),
    .instr_i        (fd_instr),
    .pc_plus_four_i (pc_inc),
    .instruction_o  (instruction_D),
    .pc_plus_four_o (pc_plus_four_D),
    .valid_o        (valid_D)
  );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clock;
  logic        reset;
  logic        stall_D;
  logic        pc_src_D;
  logic [31:0] jump_address_D;
  logic [31:0] instruction_D;
  logic [31:0] pc_plus_four_D;
  logic        valid_D;
  logic [31:0] pc_F;

  fetch_stage_if mem_if ();

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall_D        (stall_D),
    .pc_src_D       (pc_src_D),
    .jump_address_D (jump_address_D),
    .imem           (mem_if),
    .instruction_D  (instruction_D),
    .pc_plus_four_D (pc_plus_four_D),
    .valid_D        (valid_D),
    .pc_F           (pc_F)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: either driven directly by vectors, or a latency model that
  // raises ready after wait_cycles non-ready cycles of a request.
  logic        use_model;
  int          wait_cycles;
  int          mdl_cnt;
  logic        vec_ready;
  logic [31:0] vec_rdata;
  logic        model_ready;

  assign model_ready = mem_if.imem_req && (mdl_cnt == wait_cycles);
  assign mem_if.imem_ready = use_model ? model_ready : vec_ready;
  assign mem_if.imem_rdata = use_model ? mem_word(mem_if.imem_addr) : vec_rdata;

  always @(posedge clock or posedge reset) begin
    if (reset) mdl_cnt <= 0;
    else if (mem_if.imem_req && !model_ready) mdl_cnt <= mdl_cnt + 1;
    else mdl_cnt <= 0;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        src;
    logic [31:0] jump;
    logic        ready;
    logic [31:0] rdata;
    logic        exp_req;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mkv(logic st, logic sr, logic [31:0] j, logic rd, logic [31:0] d,
                               logic rq, logic ca, logic [31:0] ad, logic [31:0] ins,
                               logic [31:0] p4, logic v, logic [31:0] pc);
    vec_t r;
    r.stall = st; r.src = sr; r.jump = j; r.ready = rd; r.rdata = d;
    r.exp_req = rq; r.chk_addr = ca; r.exp_addr = ad; r.exp_instr = ins;
    r.exp_pc4 = p4; r.exp_valid = v; r.exp_pc = pc;
    return r;
  endfunction

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; stall_D = 1'b0; pc_src_D = 1'b0; jump_address_D = '0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, mem_if.imem_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_D}, 32'd0);
    check({tag, "_instr"}, instruction_D, 32'd0);
    check({tag, "_pc4"},   pc_plus_four_D, 32'd0);
    check({tag, "_pcF"},   pc_F, RPC);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall_D = 0; pc_src_D = 0; jump_address_D = '0;
    use_model = 1'b0; wait_cycles = 0; vec_ready = 0; vec_rdata = '0;

    vecs[0]  = mkv(0,0,0,1,mem_word(RPC),         1,1,RPC,          mem_word(RPC),32'h0040_0004,1,32'h0040_0004);
    vecs[1]  = mkv(0,0,0,1,mem_word(32'h0040_0004),1,1,32'h0040_0004,mem_word(32'h0040_0004),32'h0040_0008,1,32'h0040_0008);
    vecs[2]  = mkv(0,0,0,0,0,                     1,1,32'h0040_0008,0,0,0,32'h0040_0008);
    vecs[3]  = mkv(0,0,0,1,mem_word(32'h0040_0008),1,1,32'h0040_0008,mem_word(32'h0040_0008),32'h0040_000C,1,32'h0040_000C);
    vecs[4]  = mkv(1,0,0,1,mem_word(32'h0040_000C),1,1,32'h0040_000C,mem_word(32'h0040_0008),32'h0040_000C,1,32'h0040_000C);
    vecs[5]  = mkv(1,0,0,0,0,                     0,0,0,mem_word(32'h0040_0008),32'h0040_000C,1,32'h0040_000C);
    vecs[6]  = mkv(0,0,0,0,0,                     0,0,0,mem_word(32'h0040_000C),32'h0040_0010,1,32'h0040_0010);
    vecs[7]  = mkv(0,1,32'h0040_0100,1,mem_word(32'h0040_0010),1,1,32'h0040_0010,0,0,0,32'h0040_0100);
    vecs[8]  = mkv(0,1,32'h1234_5678,1,mem_word(32'h0040_0100),1,1,32'h0040_0100,mem_word(32'h0040_0100),32'h0040_0104,1,32'h0040_0104);
    vecs[9]  = mkv(1,1,32'h0040_0200,0,0,         1,1,32'h0040_0104,mem_word(32'h0040_0100),32'h0040_0104,1,32'h0040_0104);
    vecs[10] = mkv(0,1,32'h0040_0200,0,0,         1,1,32'h0040_0104,0,0,0,32'h0040_0200);
    vecs[11] = mkv(0,0,0,0,0,                     1,1,32'h0040_0104,0,0,0,32'h0040_0200);
    vecs[12] = mkv(0,0,0,1,mem_word(32'h0040_0104),1,1,32'h0040_0104,0,0,0,32'h0040_0200);
    vecs[13] = mkv(0,0,0,1,mem_word(32'h0040_0200),1,1,32'h0040_0200,mem_word(32'h0040_0200),32'h0040_0204,1,32'h0040_0204);
    vecs[14] = mkv(1,0,0,1,mem_word(32'h0040_0204),1,1,32'h0040_0204,mem_word(32'h0040_0200),32'h0040_0204,1,32'h0040_0204);
    vecs[15] = mkv(0,1,32'hFFFF_FFFC,0,0,         0,0,0,0,0,0,32'hFFFF_FFFC);
    vecs[16] = mkv(0,0,0,1,mem_word(32'hFFFF_FFFC),1,1,32'hFFFF_FFFC,mem_word(32'hFFFF_FFFC),32'h0,1,32'h0);
    vecs[17] = mkv(0,0,0,1,mem_word(32'h0),       1,1,32'h0,mem_word(32'h0),32'h4,1,32'h4);

    // Reset state while reset is held
    #2;
    check_reset_outputs("reset0");

    // Table-driven vectors
    do_reset();
    for (int i = 0; i < 18; i++) begin
      stall_D = vecs[i].stall; pc_src_D = vecs[i].src; jump_address_D = vecs[i].jump;
      vec_ready = vecs[i].ready; vec_rdata = vecs[i].rdata;
      #2;
      check($sformatf("v%0d_req", i), {31'd0, mem_if.imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].chk_addr)
        check($sformatf("v%0d_addr", i), mem_if.imem_addr, vecs[i].exp_addr);
      @(posedge clock); #1;
      check($sformatf("v%0d_instr", i), instruction_D, vecs[i].exp_instr);
      check($sformatf("v%0d_pc4", i), pc_plus_four_D, vecs[i].exp_pc4);
      check($sformatf("v%0d_valid", i), {31'd0, valid_D}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_pcF", i), pc_F, vecs[i].exp_pc);
    end
    stall_D = 0; pc_src_D = 0; vec_ready = 0;

    // Zero-wait streaming: one instruction per cycle, no gaps
    use_model = 1'b1; wait_cycles = 0;
    do_reset();
    #1;
    check("zw_first_addr", mem_if.imem_addr, RPC);
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      check($sformatf("zw%0d_valid", k), {31'd0, valid_D}, 32'd1);
      check($sformatf("zw%0d_pc4", k), pc_plus_four_D, RPC + 32'(4 * (k + 1)));
      check($sformatf("zw%0d_instr", k), instruction_D, mem_word(RPC + 32'(4 * k)));
    end

    // Two wait cycles: address stable, valid pattern 0,0,1
    wait_cycles = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        #1;
        check($sformatf("lat_addr_%0d_%0d", i, j), mem_if.imem_addr, RPC + 32'(4 * i));
        @(posedge clock); #1;
        check($sformatf("lat_valid_%0d_%0d", i, j), {31'd0, valid_D}, (j == 2) ? 32'd1 : 32'd0);
        if (j == 2)
          check($sformatf("lat_instr_%0d", i), instruction_D, mem_word(RPC + 32'(4 * i)));
      end
    end

    // Asynchronous reset while in HOLD
    wait_cycles = 0;
    do_reset();
    @(posedge clock); #1;
    stall_D = 1'b1;
    @(posedge clock); #1;
    check("hold_req", {31'd0, mem_if.imem_req}, 32'd0);
    check("hold_instr", instruction_D, mem_word(RPC));
    #2; reset = 1'b1; #1;
    check_reset_outputs("rst_hold");
    stall_D = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; #1;
    check("rst_hold_req", {31'd0, mem_if.imem_req}, 32'd1);
    check("rst_hold_addr", mem_if.imem_addr, RPC);
    @(posedge clock); #1;
    check("rst_hold_instr", instruction_D, mem_word(RPC));
    check("rst_hold_valid", {31'd0, valid_D}, 32'd1);

    // Asynchronous reset while in DISCARD
    wait_cycles = 2;
    do_reset();
    repeat (3) @(posedge clock);
    #1;
    check("dis_pre_valid", {31'd0, valid_D}, 32'd1);
    pc_src_D = 1'b1; jump_address_D = 32'h0040_0300;
    @(posedge clock); #1;
    pc_src_D = 1'b0;
    check("dis_valid", {31'd0, valid_D}, 32'd0);
    check("dis_pcF", pc_F, 32'h0040_0300);
    check("dis_req", {31'd0, mem_if.imem_req}, 32'd1);
    check("dis_addr", mem_if.imem_addr, 32'h0040_0004);
    #2; reset = 1'b1; #1;
    check_reset_outputs("rst_dis");
    @(posedge clock); #1;
    reset = 1'b0; #1;
    check("rst_dis_addr", mem_if.imem_addr, RPC);
    repeat (3) @(posedge clock);
    #1;
    check("rst_dis_valid", {31'd0, valid_D}, 32'd1);
    check("rst_dis_instr", instruction_D, mem_word(RPC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage: owns the PC register, drives a request/ready instruction-memory port, and holds the fetch/decode pipeline register (instruction, pc_plus_four, valid) that feeds decode_stage.
- Accepts the redirect (pc_src, jump_address) and the hazard-unit stall that decode produces.
- Squashes the wrong-path fetch on a taken branch or jump; no delay slot.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_D  in  1  hazard-unit stall; freezes PC and the fetch/decode register.
- pc_src_D  in  1  redirect request from decode.
- jump_address_D  in  32  redirect target from decode.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request address; word aligned.
- imem_ready  in  1  response valid this cycle; may arrive in the same cycle as the request.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- instruction_D  out  32  to decode.
- pc_plus_four_D  out  32  to decode.
- valid_D  out  1  1 = instruction_D is real; 0 = bubble.
- pc_F  out  32  current PC (debug/trace).

Behaviour:
Core definitions
- redirect = pc_src_D & valid_D & ~stall_D. pc_src_D is ignored while stalled or while decode holds a bubble.
- Bubble = instruction_D 32'h0 (sll $0 nop), pc_plus_four_D 0, valid_D 0.

Reset (asynchronous)
- pc=RESET_PC, state=RUN.
- instruction_D=0, pc_plus_four_D=0, valid_D=0.
- hold_buf=0, discard_addr=0.
- imem_req must deassert combinationally while reset is high.

Memory protocol
- Once imem_req=1, imem_addr stays stable until imem_ready=1.
- A request is never withdrawn.
- All arithmetic is 32-bit modulo; pc+4 wraps 32'hFFFF_FFFC -> 0.

State RUN: imem_req=1, imem_addr=pc.
- ready & ~stall_D & ~redirect: IF/ID <= {imem_rdata, pc+4, 1}; pc <= pc+4.
- ready & redirect: IF/ID <= bubble; pc <= jump_address_D; stay RUN.
- ready & stall_D: hold_buf <= imem_rdata; IF/ID and pc unchanged; -> HOLD.
- ~ready & redirect: discard_addr <= pc; pc <= jump_address_D; IF/ID <= bubble; -> DISCARD.
- ~ready & ~stall_D & ~redirect: IF/ID <= bubble; pc unchanged.
- ~ready & stall_D: nothing changes.

State HOLD: imem_req=0.
- stall_D: stay; hold_buf retained.
- ~stall_D & redirect: IF/ID <= bubble; pc <= jump_address_D; -> RUN. hold_buf is dropped.
- ~stall_D & ~redirect: IF/ID <= {hold_buf, pc+4, 1}; pc <= pc+4; -> RUN.

State DISCARD: imem_req=1, imem_addr=discard_addr.
- On ready, the response is dropped and state -> RUN.
- IF/ID <= bubble whenever ~stall_D. redirect cannot occur here because valid_D=0.

Other rules
- Latency: the instruction at address A appears on instruction_D the cycle after imem_ready for A. Throughput is 1/cycle with a zero-wait memory.
- Reset mid-request: state returns to RUN and the outstanding response is abandoned. The memory model must tolerate a new request after reset.
- pc_F = pc in all states.

Decomposition:
- Shared package/header:
  - state encoding constants FETCH_RUN=2'd0, FETCH_HOLD=2'd1, FETCH_DISCARD=2'd2.
  - RESET_PC default.
  - NOP_INSTRUCTION = 32'h0.
- One sub-module is natural: fetch_decode_register, holding instruction_D, pc_plus_four_D and valid_D with load/bubble/hold controls and async reset. The decode/execute boundary can reuse the same pattern later.
- The FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset, then zero-wait memory returning mem[A]=A^32'hA5A5_0000 → first imem_addr=0x0040_0000; valid_D=1 with pc_plus_four_D 0x0040_0004, 0x0040_0008, … on consecutive cycles; no gaps.
- 2-cycle memory latency → imem_addr stable while waiting; valid_D pattern 0,0,1 repeating; every instruction delivered exactly once, in order.
- stall_D high 3 cycles after a ready response → IF/ID unchanged and imem_req=0 during the stall. After release, the held word appears with correct pc_plus_four_D, then fetching resumes at pc+4.
- pc_src_D=1, jump_address_D=0x0040_0100, with the request ready the same cycle → next IF/ID is a bubble; next imem_addr=0x0040_0100; the wrong-path word never reaches valid_D=1.
- Redirect while a 3-cycle request to 0x0040_0010 is pending → imem_addr stays 0x0040_0010 until ready; that response is dropped; then the request goes to the target; valid_D stays 0 throughout.
- Assert reset mid-wait in HOLD and in DISCARD → all outputs return to reset values immediately (asynchronously); the next request is to RESET_PC. Also pc=0xFFFF_FFFC fetch → next pc 0.
